// File: rtl/fc_neuron_seq_if.sv
// Beat-in / result-out bundle for the sequential fully-connected neuron.
// The producer/consumer side uses master; the neuron itself uses slave.
interface fc_neuron_seq_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int OW    = 23
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   in_x;
    logic [LANES*WIDTH-1:0]   in_w;
    logic [OW-1:0]            bias;
    logic                     relu_en;
    logic                     out_valid;
    logic                     out_ready;
    logic [OW-1:0]            z;

    modport master (
        output in_valid, in_x, in_w, bias, relu_en, out_ready,
        input  in_ready, out_valid, z
    );

    modport slave (
        input  in_valid, in_x, in_w, bias, relu_en, out_ready,
        output in_ready, out_valid, z
    );
endinterface

// File: rtl/fc_neuron_seq.sv
// Sequential fully-connected neuron: accumulates LANES products per beat over
// IN/LANES beats, adds bias, then applies optional ReLU and saturates to OW bits.
module fc_neuron_seq #(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    parameter int LANES = 4
) (
    input  logic          clk,
    input  logic          rst,
    fc_neuron_seq_if.slave bus
);
    localparam int BEATS = IN / LANES;
    localparam int OW    = 2 * WIDTH + $clog2(IN);
    localparam int ACW   = OW + 1;
    localparam int PW    = 2 * WIDTH;
    localparam int CW    = $clog2(BEATS + 1);

    localparam logic [CW-1:0]         LAST_CNT = CW'(BEATS - 1);
    localparam logic signed [ACW-1:0] ZMAX     = {{2{1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACW-1:0] ZMIN     = {{2{1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t                 state_r, state_n;
    logic [CW-1:0]          cnt_r, cnt_n;
    logic signed [ACW-1:0]  acc_r, acc_n;
    logic                   relu_r, relu_n;
    logic                   out_valid_r, out_valid_n;
    logic [OW-1:0]          z_r, z_n;

    logic [PW-1:0]          prod_s [LANES];
    logic signed [ACW-1:0]  lane_sum_s;
    logic signed [ACW-1:0]  base_s;
    logic signed [ACW-1:0]  sum_s;
    logic                   in_ready_s;
    logic                   in_fire_s;
    logic                   last_s;
    logic                   relu_sel_s;

    // Negative values are zeroed under ReLU; everything else clamps to the OW-bit range.
    function automatic logic [OW-1:0] sat_z(input logic signed [ACW-1:0] v, input logic relu);
        logic [OW-1:0] r;
        if (relu && v[ACW-1]) begin
            r = {OW{1'b0}};
        end else if (v > ZMAX) begin
            r = ZMAX[OW-1:0];
        end else if (v < ZMIN) begin
            r = ZMIN[OW-1:0];
        end else begin
            r = v[OW-1:0];
        end
        return r;
    endfunction

    // Products are formed at full 2*WIDTH precision; low bits of the unsigned
    // product of sign-extended operands equal the signed product.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WIDTH-1:0] x_s;
        logic [WIDTH-1:0] w_s;
        assign x_s       = bus.in_x[k*WIDTH +: WIDTH];
        assign w_s       = bus.in_w[k*WIDTH +: WIDTH];
        assign prod_s[k] = {{WIDTH{x_s[WIDTH-1]}}, x_s} * {{WIDTH{w_s[WIDTH-1]}}, w_s};
    end

    // Adder tree across lanes, sign-extended to the accumulator width.
    always_comb begin
        lane_sum_s = {ACW{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            lane_sum_s = lane_sum_s + {{(ACW-PW){prod_s[k][PW-1]}}, prod_s[k]};
        end
    end

    assign in_ready_s = !rst && (state_r != OUT);
    assign in_fire_s  = bus.in_valid && in_ready_s;
    assign last_s     = (cnt_r == LAST_CNT);
    assign base_s     = (state_r == IDLE) ? {bus.bias[OW-1], bus.bias} : acc_r;
    assign sum_s      = base_s + lane_sum_s;
    assign relu_sel_s = (state_r == IDLE) ? bus.relu_en : relu_r;

    // Next-state and next-register values for the frame controller.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        acc_n       = acc_r;
        relu_n      = relu_r;
        out_valid_n = out_valid_r;
        z_n         = z_r;
        case (state_r)
            IDLE, ACCUM: begin
                if (in_fire_s) begin
                    acc_n  = sum_s;
                    cnt_n  = cnt_r + CW'(1);
                    relu_n = relu_sel_s;
                    if (last_s) begin
                        state_n     = OUT;
                        out_valid_n = 1'b1;
                        z_n         = sat_z(sum_s, relu_sel_s);
                    end else begin
                        state_n = ACCUM;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_n     = IDLE;
                    out_valid_n = 1'b0;
                    acc_n       = {ACW{1'b0}};
                    cnt_n       = {CW{1'b0}};
                end else begin
                    state_n = OUT;
                end
            end
            default: begin
                state_n     = IDLE;
                out_valid_n = 1'b0;
                acc_n       = {ACW{1'b0}};
                cnt_n       = {CW{1'b0}};
            end
        endcase
    end

    // State and datapath registers; reset wins over any concurrent transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            acc_r       <= {ACW{1'b0}};
            relu_r      <= 1'b0;
            out_valid_r <= 1'b0;
            z_r         <= {OW{1'b0}};
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            acc_r       <= acc_n;
            relu_r      <= relu_n;
            out_valid_r <= out_valid_n;
            z_r         <= z_n;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.z         = z_r;
endmodule

// File: tb/tb_fc_neuron_seq.sv
// Scoreboard bench for fc_neuron_seq: frames push expected results, a monitor
// pops them whenever the neuron hands over a result.
module tb_fc_neuron_seq;
    localparam int WIDTH = 8;
    localparam int IN    = 128;
    localparam int LANES = 4;
    localparam int OW    = 23;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   n_push;
    int   n_out;
    logic signed [OW-1:0] exp_q[$];

    fc_neuron_seq_if #(.WIDTH(WIDTH), .LANES(LANES), .OW(OW)) bus ();

    fc_neuron_seq #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: a result transfers on the next edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        logic signed [OW-1:0] e;
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'sd1, 64'sd0);
            end else begin
                e = exp_q.pop_front();
                chk("z", $signed(bus.z), e);
            end
        end
    end

    task automatic send_frame(input logic [31:0] xv, input logic [31:0] wv,
                              input logic [OW-1:0] b, input logic re,
                              input int nbeats, input bit bubbles,
                              input bit push, input logic signed [OW-1:0] expv);
        bit ok;
        int guard;
        if (push) begin
            exp_q.push_back(expv);
            n_push++;
        end
        for (int i = 0; i < nbeats; i++) begin
            if (bubbles && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_x     = $urandom;
                bus.in_w     = $urandom;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_x     = xv;
            bus.in_w     = wv;
            bus.bias     = (i == 0) ? b : OW'($urandom);
            bus.relu_en  = (i == 0) ? re : ~re;
            ok    = 1'b0;
            guard = 0;
            while (!ok && guard < 200) begin
                @(negedge clk);
                ok = (bus.in_ready === 1'b1);
                @(posedge clk); #1;
                guard++;
            end
            if (!ok) chk("in_accept_timeout", 64'sd0, 64'sd1);
        end
        bus.in_valid = 1'b0;
        if (nbeats == IN / LANES) begin
            @(negedge clk);
            chk("latency_out_valid", bus.out_valid, 64'sd1);
            chk("out_in_ready_low", bus.in_ready, 64'sd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; errors = 0; n_push = 0; n_out = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_w      = '0;
        bus.bias      = '0;
        bus.relu_en   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 64'sd0);
        chk("rst_out_valid", bus.out_valid, 64'sd0);
        chk("rst_z", $signed(bus.z), 64'sd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 64'sd1);
        @(posedge clk); #1;

        // Basic and signed-extreme frames.
        send_frame(32'h01010101, 32'h01010101, 23'sd0, 1'b1, 32, 1'b0, 1'b1, 23'sd128);
        send_frame(32'h80808080, 32'h7f7f7f7f, 23'sd0, 1'b0, 32, 1'b0, 1'b1, -23'sd2080768);
        send_frame(32'h80808080, 32'h7f7f7f7f, 23'sd0, 1'b1, 32, 1'b0, 1'b1, 23'sd0);
        send_frame(32'h80808080, 32'h80808080, 23'sd4194303, 1'b0, 32, 1'b0, 1'b1, 23'sd4194303);
        send_frame(32'h01010101, 32'hffffffff, -23'sd4194304, 1'b0, 32, 1'b0, 1'b1, -23'sd4194304);
        // Mixed lanes: per beat 1*5 - 2*6 + 3*(-7) - 4*8 = -60.
        send_frame(32'hfc03fe01, 32'h08f90605, 23'sd100, 1'b0, 32, 1'b1, 1'b1, -23'sd1820);
        send_frame(32'hfc03fe01, 32'h08f90605, 23'sd3000, 1'b1, 32, 1'b1, 1'b1, 23'sd1080);

        // Result held under back-pressure while new beats are offered.
        bus.out_ready = 1'b0;
        send_frame(32'h01010101, 32'h02020202, 23'sd5, 1'b0, 32, 1'b0, 1'b1, 23'sd261);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = 32'h03030303;
            bus.in_w     = 32'h03030303;
            bus.bias     = 23'sd77;
            @(negedge clk);
            chk("hold_z", $signed(bus.z), 64'sd261);
            chk("hold_out_valid", bus.out_valid, 64'sd1);
            chk("hold_in_ready", bus.in_ready, 64'sd0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_out_in_ready", bus.in_ready, 64'sd1);
        chk("after_out_valid", bus.out_valid, 64'sd0);
        chk("after_out_z_retained", $signed(bus.z), 64'sd261);
        @(posedge clk); #1;

        // Reset while a result is held discards it.
        bus.out_ready = 1'b0;
        send_frame(32'h01010101, 32'h01010101, 23'sd0, 1'b0, 32, 1'b0, 1'b0, 23'sd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_hold_in_ready", bus.in_ready, 64'sd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hold_out_valid", bus.out_valid, 64'sd0);
        chk("rst_hold_z", $signed(bus.z), 64'sd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;

        // Reset mid-frame with a beat offered, then a bubbly frame: 128*6 - 10.
        send_frame(32'h02020202, 32'h03030303, -23'sd10, 1'b0, 10, 1'b0, 1'b0, 23'sd0);
        bus.in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        send_frame(32'h02020202, 32'h03030303, -23'sd10, 1'b0, 32, 1'b1, 1'b1, 23'sd758);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 64'sd0);
        chk("output_count", n_out, n_push);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
